// File: rtl/riscv_defines.sv
// Shared RV32 fetch-side definitions: word widths, reset constants and the
// fetch-buffer entry layout.
package riscv_defines;
    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [ILEN-1:0] DEF_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc_plus_4;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/instruction_fetch_stage_fetch_buffer.sv
// Small synchronous FIFO holding returned fetch words until IF/ID takes them.
// Clear has priority over push and pop.
module fetch_buffer
    import riscv_defines::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] rdata,
    output logic               full,
    output logic               empty,
    output logic [CW-1:0]      count
);
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is data only; validity lives in count, so no reset needed here.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        (push && !clear) |-> (!full || pop));
endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the fetch PC, issues credit-limited in-order fetches, drops
// stale responses after a redirect and presents the buffer head to IF/ID.
module instruction_fetch_stage
    import riscv_defines::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc_plus_4,
    output logic        if_valid
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [31:0]        fetch_pc;
    logic [31:0]        resp_pc;
    logic [31:0]        target_pc;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      drop;
    logic [CW-1:0]      occupancy;
    logic [CW:0]        credits_used;
    logic               issue;
    logic               pop;
    logic               accept;
    logic               buf_empty;
    logic               buf_full;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;
    logic [ENTRY_W-1:0] head_bits;
    logic               unused_bits;

    assign target_pc   = {redirect_pc[31:2], 2'b00};
    assign unused_bits = ^{redirect_pc[1:0], buf_full};

    // A head leaving this cycle frees its slot now, which keeps 1 instr/cycle
    // streaming with a 2-entry buffer.
    assign pop          = !buf_empty && !stall;
    assign credits_used = {1'b0, inflight} + {1'b0, occupancy} - {{CW{1'b0}}, pop};
    assign imem_req     = reset && !redirect && (credits_used < (CW+1)'(BUF_DEPTH));
    assign imem_addr    = fetch_pc;
    assign issue        = imem_req && imem_gnt;

    assign accept               = imem_rvalid && (drop == '0) && !redirect;
    assign push_entry.instr     = imem_rdata;
    assign push_entry.pc_plus_4 = resp_pc + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect) begin
            // Everything still outstanding after this cycle belongs to the old path.
            fetch_pc <= target_pc;
            resp_pc  <= target_pc;
            inflight <= inflight - CW'(imem_rvalid);
            drop     <= inflight - CW'(imem_rvalid);
        end else begin
            if (issue)  fetch_pc <= fetch_pc + 32'd4;
            if (accept) resp_pc  <= resp_pc + 32'd4;
            inflight <= inflight + CW'(issue) - CW'(imem_rvalid);
            if (imem_rvalid && (drop != '0)) drop <= drop - 1'b1;
        end
    end

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_fetch_buffer (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .clear (redirect),
        .wdata (push_entry),
        .rdata (head_bits),
        .full  (buf_full),
        .empty (buf_empty),
        .count (occupancy)
    );

    assign head           = fetch_entry_t'(head_bits);
    assign if_valid       = !buf_empty;
    assign if_instruction = buf_empty ? NOP_INSTR : head.instr;
    assign if_pc_plus_4   = buf_empty ? 32'h0 : head.pc_plus_4;

    a_rvalid_expected: assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> (inflight != '0));
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with an in-order memory model
// whose read data is addr + 0x1_0000.
module tb_instruction_fetch_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_plus_4;
    logic        if_valid;

    logic        mem_hold;
    logic [31:0] mem_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    instruction_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_instruction (if_instruction),
        .if_pc_plus_4   (if_pc_plus_4),
        .if_valid       (if_valid)
    );

    always #5 clk = ~clk;

    // Responds one cycle after issue unless held; reset with the DUT.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
        end else begin
            if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
            if (!mem_hold && mem_q.size() > 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_q.pop_front() + 32'h0001_0000;
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b1; mem_hold = 1'b0;

        // Reset values
        tick(); #1;
        chk("rst_req",   {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_instr", if_instruction,    32'h0000_0013);
        chk("rst_pc4",   if_pc_plus_4,      32'h0);

        // 1: streaming fetch after release
        tick(); reset = 1'b1; #1;
        chk("t1_req0",  {31'h0, imem_req}, 32'h1);
        chk("t1_addr0", imem_addr,         32'h0);
        tick(); #1;
        chk("t1_addr1",   imem_addr,         32'h4);
        chk("t1_novalid", {31'h0, if_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("t1_valid", {31'h0, if_valid}, 32'h1);
            chk("t1_pc4",   if_pc_plus_4,      32'(4*k + 4));
            chk("t1_instr", if_instruction,    32'h0001_0000 + 32'(4*k));
            chk("t1_addr",  imem_addr,         32'(4*k + 8));
        end

        // 2: stall for 5 cycles
        tick(); stall = 1'b1; #1;
        chk("t2_req_off", {31'h0, imem_req}, 32'h0);
        chk("t2_pc4",     if_pc_plus_4,      32'h14);
        chk("t2_instr",   if_instruction,    32'h0001_0010);
        repeat (4) begin
            tick(); #1;
            chk("t2_req_held", {31'h0, imem_req}, 32'h0);
            chk("t2_pc4_held", if_pc_plus_4,      32'h14);
            chk("t2_valid",    {31'h0, if_valid}, 32'h1);
        end
        tick(); stall = 1'b0; #1;
        chk("t2_rel_pc4",  if_pc_plus_4,      32'h14);
        chk("t2_rel_req",  {31'h0, imem_req}, 32'h1);
        chk("t2_rel_addr", imem_addr,         32'h18);
        tick(); #1;
        chk("t2_next_pc4",   if_pc_plus_4,   32'h18);
        chk("t2_next_instr", if_instruction, 32'h0001_0014);
        tick(); #1;
        chk("t2_next2_pc4",   if_pc_plus_4,   32'h1C);
        chk("t2_next2_instr", if_instruction, 32'h0001_0018);

        // 3: redirect to 0x100 with two fetches outstanding
        mem_hold = 1'b1;
        tick(); #1;
        chk("t3_pc4", if_pc_plus_4, 32'h20);
        tick(); #1;
        chk("t3_empty",   {31'h0, if_valid}, 32'h0);
        chk("t3_credits", {31'h0, imem_req}, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h100; mem_hold = 1'b0;
        tick(); redirect = 1'b0; #1;
        chk("t3_flush", {31'h0, if_valid}, 32'h0);
        chk("t3_req",   {31'h0, imem_req}, 32'h0);
        tick(); #1;
        chk("t3_drop1", {31'h0, if_valid}, 32'h0);
        chk("t3_addr",  imem_addr,         32'h100);
        chk("t3_reqon", {31'h0, imem_req}, 32'h1);
        tick(); #1;
        chk("t3_drop2", {31'h0, if_valid}, 32'h0);
        chk("t3_addr2", imem_addr,         32'h104);
        tick(); #1;
        chk("t3_valid", {31'h0, if_valid}, 32'h1);
        chk("t3_pc4",   if_pc_plus_4,      32'h104);
        chk("t3_instr", if_instruction,    32'h0001_0100);

        // 4: grant withheld for 3 cycles
        imem_gnt = 1'b0;
        tick(); #1;
        chk("t4_pc4",   if_pc_plus_4,      32'h108);
        chk("t4_req1",  {31'h0, imem_req}, 32'h1);
        chk("t4_addr1", imem_addr,         32'h108);
        tick(); #1;
        chk("t4_req2",  {31'h0, imem_req}, 32'h1);
        chk("t4_addr2", imem_addr,         32'h108);
        tick(); #1;
        chk("t4_req3",  {31'h0, imem_req}, 32'h1);
        chk("t4_addr3", imem_addr,         32'h108);
        imem_gnt = 1'b1;
        tick(); #1;
        chk("t4_addr_adv", imem_addr, 32'h10C);
        tick(); #1;
        chk("t4_valid", {31'h0, if_valid}, 32'h1);
        chk("t4_rpc4",  if_pc_plus_4,      32'h10C);
        chk("t4_instr", if_instruction,    32'h0001_0108);

        // 5: redirect and stall together, unaligned target
        tick(); redirect = 1'b1; redirect_pc = 32'h203; stall = 1'b1; #1;
        chk("t5_req", {31'h0, imem_req}, 32'h0);
        chk("t5_pc4", if_pc_plus_4,      32'h110);
        tick(); redirect = 1'b0; stall = 1'b0; #1;
        chk("t5_flush", {31'h0, if_valid}, 32'h0);
        chk("t5_reqon", {31'h0, imem_req}, 32'h1);
        chk("t5_addr",  imem_addr,         32'h200);
        tick(); #1;
        chk("t5_addr2", imem_addr, 32'h204);
        tick(); #1;
        chk("t5_valid", {31'h0, if_valid}, 32'h1);
        chk("t5_pc4v",  if_pc_plus_4,      32'h204);
        chk("t5_instr", if_instruction,    32'h0001_0200);

        // 6: PC wrap, then async reset mid-burst
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick(); redirect = 1'b0; #1;
        chk("t6_addr0", imem_addr,         32'hFFFF_FFF8);
        chk("t6_empty", {31'h0, if_valid}, 32'h0);
        tick(); #1;
        chk("t6_addr1", imem_addr, 32'hFFFF_FFFC);
        tick(); #1;
        chk("t6_pc4a",  if_pc_plus_4,   32'hFFFF_FFFC);
        chk("t6_instr", if_instruction, 32'h0000_FFF8);
        chk("t6_wrap",  imem_addr,      32'h0);
        tick(); #1;
        chk("t6_valid", {31'h0, if_valid}, 32'h1);
        chk("t6_pc4b",  if_pc_plus_4,      32'h0);
        chk("t6_instr2", if_instruction,   32'h0000_FFFC);
        chk("t6_addr4", imem_addr,         32'h4);
        #2; reset = 1'b0; #1;
        chk("t6_rst_req",   {31'h0, imem_req}, 32'h0);
        chk("t6_rst_valid", {31'h0, if_valid}, 32'h0);
        chk("t6_rst_instr", if_instruction,    32'h0000_0013);
        chk("t6_rst_pc4",   if_pc_plus_4,      32'h0);
        tick(); reset = 1'b1; #1;
        chk("t6_rel_req",  {31'h0, imem_req}, 32'h1);
        chk("t6_rel_addr", imem_addr,         32'h0);
        tick(); #1;
        chk("t6_rel_addr2", imem_addr,         32'h4);
        chk("t6_rel_empty", {31'h0, if_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
